// File: rtl/prefix_sub_stream_pkg.sv
// Shared types and elaboration helpers for the streaming prefix subtractor.
// Holds the FSM state type, legal beat-width bounds and the generate/propagate prefix cell.
package prefix_sub_stream_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam int W_MIN = 2;
   localparam int W_MAX = 64;

   function automatic int log2_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic bit w_legal(input int n);
      return (n >= W_MIN) && (n <= W_MAX) && ((n & (n - 1)) == 0);
   endfunction

   // Prefix cell: combine {g,p} of a high span with the adjacent low span.
   function automatic logic [1:0] gp_cell(input logic [1:0] hi, input logic [1:0] lo);
      return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
   endfunction

endpackage

// File: rtl/prefix_sub_stream_core.sv
// sklansky_sub_core: combinational W-bit a + ~b + cin using a Sklansky prefix tree.
// Carry-in is folded in after the tree: c[i] = G[i-1:0] | P[i-1:0] & cin.
module sklansky_sub_core
   import prefix_sub_stream_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] diff,
   output logic         cout
);

   localparam int LVL = log2_f(W);

   logic [W-1:0] g_s [LVL+1];
   logic [W-1:0] p_s [LVL+1];
   logic [W-1:0] c_s;

   assign g_s[0] = a & ~b;
   assign p_s[0] = a ^ ~b;

   // Each level doubles the resolved span; odd blocks fan in from the top of the even block below.
   for (genvar lv = 0; lv < LVL; lv++) begin : g_lvl
      for (genvar i = 0; i < W; i++) begin : g_bit
         localparam int BLK = 1 << lv;
         if (((i / BLK) % 2) == 1) begin : g_cell
            localparam int J = ((i / (2 * BLK)) * (2 * BLK)) + BLK - 1;
            assign {g_s[lv+1][i], p_s[lv+1][i]} =
               gp_cell({g_s[lv][i], p_s[lv][i]}, {g_s[lv][J], p_s[lv][J]});
         end else begin : g_pass
            assign g_s[lv+1][i] = g_s[lv][i];
            assign p_s[lv+1][i] = p_s[lv][i];
         end
      end
   end

   assign c_s[0] = cin;
   for (genvar i = 1; i < W; i++) begin : g_carry
      assign c_s[i] = g_s[LVL][i-1] | (p_s[LVL][i-1] & cin);
   end

   assign diff = p_s[0] ^ c_s;
   assign cout = g_s[LVL][W-1] | (p_s[LVL][W-1] & cin);

endmodule

// File: rtl/prefix_sub_stream.sv
// Streaming multi-beat subtractor (A - B, LSB beat first) with a chained borrow and a registered output stage.
// Optional macro PREFIX_SUB_ZERO_FLAG_EN adds out_zero, set on the last beat when the whole difference is zero.
module prefix_sub_stream
   import prefix_sub_stream_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_first,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_diff,
   output logic         out_last,
   output logic         out_bout,
`ifdef PREFIX_SUB_ZERO_FLAG_EN
   output logic         out_zero,
`endif
   output logic         out_err
);

   if (!w_legal(W)) begin : g_bad_w
      $error("prefix_sub_stream: W must be a power of two in 2..64");
   end

   state_e       state_q;
   state_e       state_d;
   logic         carry_q;
   logic         accept_s;
   logic         first_s;
   logic         err_s;
   logic         cin_s;
   logic [W-1:0] diff_s;
   logic         cout_s;

   logic         out_valid_q;
   logic [W-1:0] out_diff_q;
   logic         out_last_q;
   logic         out_bout_q;
   logic         out_err_q;

   assign in_ready = ~out_valid_q | out_ready;
   assign accept_s = in_valid & in_ready;
   assign cin_s    = first_s ? 1'b1 : carry_q;

   sklansky_sub_core #(.W(W)) u_core (
      .a    (in_a),
      .b    (in_b),
      .cin  (cin_s),
      .diff (diff_s),
      .cout (cout_s)
   );

   // In IDLE every beat starts an operand; in BUSY an early in_first restarts it and is flagged.
   always_comb begin
      state_d = state_q;
      first_s = 1'b1;
      err_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            first_s = 1'b1;
            err_s   = 1'b0;
            if (accept_s) begin
               state_d = in_last ? ST_IDLE : ST_BUSY;
            end else begin
               state_d = state_q;
            end
         end
         ST_BUSY: begin
            first_s = in_first;
            err_s   = in_first;
            if (accept_s) begin
               state_d = in_last ? ST_IDLE : ST_BUSY;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and inter-beat carry advance only on an accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         carry_q <= 1'b1;
      end else if (accept_s) begin
         state_q <= state_d;
         carry_q <= cout_s;
      end else begin
         state_q <= state_q;
         carry_q <= carry_q;
      end
   end

   // Output register: reload on accept, otherwise drop valid once the consumer takes the beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_diff_q  <= {W{1'b0}};
         out_last_q  <= 1'b0;
         out_bout_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else if (accept_s) begin
         out_valid_q <= 1'b1;
         out_diff_q  <= diff_s;
         out_last_q  <= in_last;
         out_bout_q  <= in_last & ~cout_s;
         out_err_q   <= err_s;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_diff  = out_diff_q;
   assign out_last  = out_last_q;
   assign out_bout  = out_bout_q;
   assign out_err   = out_err_q;

`ifdef PREFIX_SUB_ZERO_FLAG_EN
   logic zero_q;
   logic out_zero_q;
   logic zero_hit_s;

   assign zero_hit_s = (first_s | zero_q) & (diff_s == {W{1'b0}});

   // Sticky all-zero tracker, re-seeded by every first beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q     <= 1'b1;
         out_zero_q <= 1'b0;
      end else if (accept_s) begin
         zero_q     <= zero_hit_s;
         out_zero_q <= in_last & zero_hit_s;
      end else begin
         zero_q     <= zero_q;
         out_zero_q <= out_zero_q;
      end
   end

   assign out_zero = out_zero_q;
`endif

endmodule

// File: tb/tb_prefix_sub_stream.sv
// Self-checking bench for prefix_sub_stream (W=4): whole-operand arithmetic model plus directed literal checks.
// Build with PREFIX_SUB_ZERO_FLAG_EN defined to also exercise out_zero.
module tb_prefix_sub_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       in_first;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_diff;
   logic       out_last;
   logic       out_bout;
   logic       out_err;
`ifdef PREFIX_SUB_ZERO_FLAG_EN
   logic       out_zero;
   logic       exp_zero;
`endif

   int checks   = 0;
   int failures = 0;
   logic mon_en = 1'b0;

   logic       exp_valid;
   logic [3:0] exp_diff;
   logic       exp_last;
   logic       exp_bout;
   logic       exp_err;
   logic       acc_flag;
   logic       m_in_op;
   int         m_k;
   longint unsigned m_a;
   longint unsigned m_b;

   prefix_sub_stream #(.W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_first  (in_first),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_diff  (out_diff),
      .out_last  (out_last),
      .out_bout  (out_bout),
`ifdef PREFIX_SUB_ZERO_FLAG_EN
      .out_zero  (out_zero),
`endif
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Model: operands kept as whole integers; beat k of the result is a slice of (A - B).
   always @(posedge clk) begin : p_model
      automatic logic acc;
      automatic logic first;
      automatic longint unsigned na;
      automatic longint unsigned nb;
      automatic longint unsigned nd;
      automatic int nk;
      if (rst) begin
         exp_valid <= 1'b0;
         exp_diff  <= 4'd0;
         exp_last  <= 1'b0;
         exp_bout  <= 1'b0;
         exp_err   <= 1'b0;
`ifdef PREFIX_SUB_ZERO_FLAG_EN
         exp_zero  <= 1'b0;
`endif
         m_in_op   <= 1'b0;
         m_k       <= 0;
         m_a       <= 64'd0;
         m_b       <= 64'd0;
         acc_flag  <= 1'b0;
      end else begin
         acc = in_valid && (!exp_valid || out_ready);
         acc_flag <= acc;
         if (acc) begin
            first = !m_in_op || in_first;
            na = first ? 64'd0 : m_a;
            nb = first ? 64'd0 : m_b;
            nk = first ? 0 : m_k;
            na = na | (64'(in_a) << (4 * nk));
            nb = nb | (64'(in_b) << (4 * nk));
            nd = na - nb;
            exp_valid <= 1'b1;
            exp_diff  <= 4'((nd >> (4 * nk)) & 64'hF);
            exp_last  <= in_last;
            exp_bout  <= in_last && (na < nb);
            exp_err   <= m_in_op && in_first;
`ifdef PREFIX_SUB_ZERO_FLAG_EN
            exp_zero  <= in_last && ((nd & ((64'd1 << (4 * (nk + 1))) - 64'd1)) == 64'd0);
`endif
            m_a     <= na;
            m_b     <= nb;
            m_k     <= nk + 1;
            m_in_op <= !in_last;
         end else if (exp_valid && out_ready) begin
            exp_valid <= 1'b0;
         end
      end
   end

   // Compare DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", out_valid, exp_valid);
         chk("in_ready", in_ready, !exp_valid || out_ready);
         if (exp_valid) begin
            chk("out_diff", out_diff, exp_diff);
            chk("out_last", out_last, exp_last);
            chk("out_bout", out_bout, exp_bout);
            chk("out_err", out_err, exp_err);
`ifdef PREFIX_SUB_ZERO_FLAG_EN
            chk("out_zero", out_zero, exp_zero);
`endif
         end
      end
   end

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic f, input logic l);
      int guard;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_first = f;
      in_last  = l;
      guard    = 0;
      do begin
         @(posedge clk);
         #1;
         guard++;
      end while (!acc_flag && guard < 50);
      if (!acc_flag) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=no_accept expected=accept at %0t", $time);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 4'd0;
      in_b      = 4'd0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_diff", out_diff, 4'd0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_bout", out_bout, 1'b0);
      chk("rst_err", out_err, 1'b0);
`ifdef PREFIX_SUB_ZERO_FLAG_EN
      chk("rst_zero", out_zero, 1'b0);
`endif
      rst = 1'b0;
      idle(1);

      send(4'd5, 4'd3, 1'b1, 1'b1);
      chk("t1_diff", out_diff, 4'h2);
      chk("t1_bout", out_bout, 1'b0);
      chk("t1_last", out_last, 1'b1);
      send(4'd3, 4'd5, 1'b1, 1'b1);
      chk("t2_diff", out_diff, 4'hE);
      chk("t2_bout", out_bout, 1'b1);
      send(4'd0, 4'd1, 1'b1, 1'b0);
      chk("t3a_diff", out_diff, 4'hF);
      chk("t3a_bout", out_bout, 1'b0);
      send(4'd2, 4'd0, 1'b0, 1'b1);
      chk("t3b_diff", out_diff, 4'h1);
      chk("t3b_bout", out_bout, 1'b0);
      idle(2);

      // Backpressure: 0x431 - 0x410 = 0x021
      out_ready = 1'b0;
      send(4'd1, 4'd0, 1'b1, 1'b0);
      chk("bp_first", out_diff, 4'h1);
      in_a     = 4'd3;
      in_b     = 4'd1;
      in_first = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_ready", in_ready, 1'b0);
         chk("bp_hold", out_diff, 4'h1);
      end
      out_ready = 1'b1;
      send(4'd3, 4'd1, 1'b0, 1'b0);
      chk("bp_b1", out_diff, 4'h2);
      send(4'd4, 4'd4, 1'b0, 1'b1);
      chk("bp_b2", out_diff, 4'h0);
      chk("bp_bout", out_bout, 1'b0);
      idle(1);

      // Restart mid-operand, then confirm the FSM went back to IDLE.
      send(4'd1, 4'd2, 1'b1, 1'b0);
      send(4'd7, 4'd2, 1'b1, 1'b1);
      chk("err_diff", out_diff, 4'h5);
      chk("err_flag", out_err, 1'b1);
      send(4'd9, 4'd1, 1'b0, 1'b1);
      chk("idle_diff", out_diff, 4'h8);
      chk("idle_err", out_err, 1'b0);

      // Reset mid-operand with a pending borrow.
      send(4'd0, 4'd1, 1'b1, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_diff", out_diff, 4'h0);
      chk("mrst_err", out_err, 1'b0);
      send(4'd6, 4'd2, 1'b0, 1'b1);
      chk("mrst_next", out_diff, 4'h4);
      chk("mrst_bout", out_bout, 1'b0);

      send(4'd3, 4'd3, 1'b1, 1'b0);
      send(4'd3, 4'd3, 1'b0, 1'b1);
      chk("z1_diff", out_diff, 4'h0);
`ifdef PREFIX_SUB_ZERO_FLAG_EN
      chk("z1_zero", out_zero, 1'b1);
`endif
      send(4'd3, 4'd3, 1'b1, 1'b0);
      send(4'd4, 4'd3, 1'b0, 1'b1);
      chk("z2_diff", out_diff, 4'h1);
`ifdef PREFIX_SUB_ZERO_FLAG_EN
      chk("z2_zero", out_zero, 1'b0);
`endif

      // Mixed traffic with random stalls; the compare process does the checking.
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = 4'($urandom_range(0, 15));
         in_b      = 4'($urandom_range(0, 15));
         in_first  = ($urandom_range(0, 7) == 0);
         in_last   = ($urandom_range(0, 2) == 0) || (m_in_op && m_k >= 6);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
